// File: rtl/sd_spi_card_responder.sv
// sd_spi_card_responder: SPI-mode SD card model answering commands and single-block reads
module sd_spi_card_responder #(
   parameter int          BLOCK_BYTES = 512,
   parameter int          NCR_BYTES   = 1,
   parameter int          NAC_BYTES   = 2,
   parameter logic [31:0] OCR_VALUE   = 32'hC0FF8000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        CS,
   input  logic        D1,
   output logic        D0,
   output logic        mem_rd,
   output logic [31:0] mem_addr,
   input  logic [7:0]  mem_data,
   output logic        cmd_valid,
   output logic [5:0]  cmd_index,
   output logic [31:0] cmd_arg,
   output logic        in_idle
);
   typedef enum logic [2:0] {WAIT, RX_CMD, NCR, TX_RESP, NAC, TX_TOKEN, TX_DATA, TX_CRC} state_t;
   localparam logic [15:0] NCR_LAST  = 16'(NCR_BYTES * 8 - 1);
   localparam logic [15:0] NAC_LAST  = 16'(NAC_BYTES * 8 - 1);
   localparam logic [15:0] DATA_LAST = 16'(BLOCK_BYTES * 8 - 1);
   state_t state, state_n;
   logic [15:0] cnt, crc, crc_n;
   logic [37:0] rx;
   logic [39:0] tx, resp;
   logic [7:0]  nxt, r1_i;
   logic [5:0]  idx;
   logic [31:0] arg;
   logic        prev, app_cmd, is_read, resp_long, long_n, read_n, last;
   assign last  = cnt == 16'd0;
   assign idx   = rx[37:32];
   assign arg   = rx[31:0];
   assign r1_i  = {7'b0, in_idle};
   assign crc_n = {crc[14:0], 1'b0} ^ ((crc[15] ^ tx[39]) ? 16'h1021 : 16'h0000);
   // Response selection for the frame whose end bit is on D1 this cycle
   always_comb begin
      resp   = {r1_i | 8'h04, 32'h0};
      long_n = 1'b0;
      read_n = 1'b0;
      if (!D1) resp = {r1_i | 8'h08, 32'h0};
      else
         case (idx)
            6'd0:                resp[39:32] = 8'h01;
            6'd8:                begin resp = {r1_i, 24'h000001, arg[7:0]}; long_n = 1'b1; end
            6'd16, 6'd55, 6'd59: resp[39:32] = r1_i;
            6'd41:               if (app_cmd) resp[39:32] = r1_i;
            6'd58:               begin resp = {r1_i, OCR_VALUE}; long_n = 1'b1; end
            6'd17:               begin resp[39:32] = in_idle ? 8'h05 : 8'h00; read_n = !in_idle; end
            default:             ;
         endcase
   end
   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state <= WAIT;
      else state <= state_n;
   end
   // Next state: each phase ends when its down-counter reaches zero; CS high aborts
   always_comb begin
      state_n = state;
      case (state)
         WAIT:     state_n = (!prev && D1) ? RX_CMD : WAIT;
         RX_CMD:   state_n = last ? NCR : RX_CMD;
         NCR:      state_n = last ? TX_RESP : NCR;
         TX_RESP:  state_n = last ? (is_read ? NAC : WAIT) : TX_RESP;
         NAC:      state_n = last ? TX_TOKEN : NAC;
         TX_TOKEN: state_n = last ? TX_DATA : TX_TOKEN;
         TX_DATA:  state_n = last ? TX_CRC : TX_DATA;
         TX_CRC:   state_n = last ? WAIT : TX_CRC;
         default:  state_n = WAIT;
      endcase
      if (CS) state_n = WAIT;
   end
   // Datapath: frame shifting, decode, serialiser, block prefetch and CRC16
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         D0        <= 1'b1;
         mem_rd    <= 1'b0;
         mem_addr  <= 32'h0;
         cmd_valid <= 1'b0;
         cmd_index <= 6'h0;
         cmd_arg   <= 32'h0;
         in_idle   <= 1'b1;
         app_cmd   <= 1'b0;
         prev      <= 1'b1;
         cnt       <= 16'h0;
         rx        <= 38'h0;
         tx        <= 40'h0;
         nxt       <= 8'h0;
         crc       <= 16'h0;
         is_read   <= 1'b0;
         resp_long <= 1'b0;
      end else begin
         D0        <= 1'b1;
         mem_rd    <= 1'b0;
         cmd_valid <= 1'b0;
         cnt       <= cnt - 16'd1;
         prev      <= (state == WAIT && !CS) ? D1 : 1'b1;
         if (mem_rd) nxt <= mem_data;
         if (!CS)
            case (state)
               WAIT: if (!prev && D1) cnt <= 16'd45;
               RX_CMD: begin
                  if (cnt >= 16'd8) rx <= {rx[36:0], D1};
                  if (last) begin
                     cmd_valid <= 1'b1;
                     cmd_index <= idx;
                     cmd_arg   <= arg;
                     tx        <= resp;
                     resp_long <= long_n;
                     is_read   <= read_n;
                     cnt       <= NCR_LAST;
                     app_cmd   <= D1 && idx == 6'd55;
                     if (D1 && idx == 6'd0) in_idle <= 1'b1;
                     if (D1 && idx == 6'd41 && app_cmd) in_idle <= 1'b0;
                  end
               end
               NCR: if (last) cnt <= resp_long ? 16'd39 : 16'd7;
               TX_RESP: begin
                  D0 <= tx[39];
                  tx <= {tx[38:0], 1'b0};
                  if (last) cnt <= NAC_LAST;
               end
               NAC: if (last) begin
                  cnt <= 16'd7;
                  tx  <= {8'hFE, 32'h0};
               end
               TX_TOKEN: begin
                  D0 <= tx[39];
                  tx <= last ? {nxt, 32'h0} : {tx[38:0], 1'b0};
                  if (cnt == 16'd7) begin
                     mem_rd   <= 1'b1;
                     mem_addr <= cmd_arg;
                  end
                  if (last) begin
                     cnt <= DATA_LAST;
                     crc <= 16'h0;
                  end
               end
               TX_DATA: begin
                  D0  <= tx[39];
                  crc <= crc_n;
                  tx  <= (cnt[2:0] == 3'd0) ? {(last ? crc_n : {nxt, 8'h0}), 24'h0} : {tx[38:0], 1'b0};
                  if (cnt[2:0] == 3'd7 && cnt != 16'd7) begin
                     mem_rd   <= 1'b1;
                     mem_addr <= mem_addr + 32'd1;
                  end
                  if (last) cnt <= 16'd15;
               end
               TX_CRC: begin
                  D0 <= tx[39];
                  tx <= {tx[38:0], 1'b0};
               end
               default: ;
            endcase
      end
   end
endmodule
